// File: rtl/button_pkg.sv
// Shared types and channel indices for the push-button conditioning front end.
package button_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Channel indices into button_in / button_pulse / button_level.
  localparam int unsigned BTN_PLAY = 0;
  localparam int unsigned BTN_NEXT = 1;

endpackage : button_pkg

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM with a shared
// down-counter, and a registered single-cycle press pulse.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o,
  output logic level_o
);

  localparam int unsigned     CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   ONE    = CW'(1);

  logic          meta_q;
  logic          sync_q;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          accept_q, accept_d;
  logic          pulse_q;

  // Bring the asynchronous raw level into the clk domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
    end
  end

  // FSM state, counter and pulse registers.
  // accept_q marks the PRESS_WAIT->PRESSED edge; pulse_q follows it one
  // cycle later so the pulse lands in the cycle after the transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= RELOAD;
      accept_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      pulse_q  <= accept_q;
    end
  end

  // Next-state and counter logic: a full stable window is needed to move
  // between the released and pressed sides; any opposing sample restarts it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = RELOAD;
        if (sync_q) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = RELOAD;
        end else if (cnt_q == '0) begin
          state_d  = PRESSED;
          accept_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      PRESSED: begin
        cnt_d = RELOAD;
        if (!sync_q) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = RELOAD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = RELOAD;
      end
    endcase
  end

  assign pulse_o = pulse_q;
  assign level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects NUM_BUTTONS independent
// push-button inputs; bit 0 is play, bit 1 is next.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_in,
  output logic [NUM_BUTTONS-1:0] button_pulse,
  output logic [NUM_BUTTONS-1:0] button_level
);

  // One fully independent conditioner per button.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i  (clk),
      .rst_ni (reset),
      .btn_i  (button_in[i]),
      .pulse_o(button_pulse[i]),
      .level_o(button_level[i])
    );
  end

endmodule : button_conditioner
